symbol_repeat_upsample: RTL and testbench
=========================================

// Module: symbol_repeat_upsample
// PURPOSE
//  Parametrised symbol-rate to sample-rate upsampler for the BTLE TX chain; sits between the
//  bit/symbol source (whitening/GFSK prep) and the Gaussian filter. Accepts DATA_WIDTH-bit symbols
//  over a valid/ready handshake into a small FIFO. Emits each symbol SAMPLE_PER_SYMBOL times, one
//  sample strobe every CLK_PER_SAMPLE clocks. Frames packets with an aligned last flag and flags
//  mid-packet underrun.
// PARAMETERS
//  SAMPLE_PER_SYMBOL  8  output samples per input symbol (>=2)
//  CLK_PER_SAMPLE     2  clk cycles between output strobes (>=1; 1 = strobe every cycle)
//  DATA_WIDTH         1  symbol width in bits
//  FIFO_DEPTH         4  input FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1           system clock (16 MHz in default config)
//  rst_n      in   1           asynchronous active-low reset
//  in_data    in   DATA_WIDTH  input symbol
//  in_valid   in   1           in_data valid
//  in_last    in   1           in_data is final symbol of packet
//  in_ready   out  1           FIFO can accept; transfer when in_valid&in_ready
//  out_data   out  DATA_WIDTH  upsampled symbol (held between strobes)
//  out_valid  out  1           one-cycle sample strobe
//  out_last   out  1           with out_valid on final sample of a last-tagged symbol
//  busy       out  1           FIFO non-empty or state ACTIVE
//  underrun   out  1           sticky: stream starved mid-packet
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1. FIFO empty, state IDLE, counters 0, underrun 0.
//  FIFO: {in_last,in_data} stored. in_ready = ~full (registered count; no same-cycle bypass).
//  Push on in_valid&in_ready. Pop is engine-driven. Simultaneous push+pop keeps the count.
//  States: IDLE, ACTIVE.
//   IDLE -> ACTIVE when FIFO non-empty: pop, load out_data/cur_last.
//   Set phase_cnt=0 and samp_cnt=0; the first out_valid occurs the cycle after the load.
//  Latency: symbol pushed at edge t into an empty FIFO while IDLE: popped at edge t+1, first
//  out_valid during cycle t+2.
//  ACTIVE:
//   phase_cnt counts 0..CLK_PER_SAMPLE-1 and wraps; out_valid=1 when phase_cnt==0.
//   samp_cnt increments on each strobe and wraps 0..SAMPLE_PER_SYMBOL-1.
//   out_data changes only on a load. Exactly SAMPLE_PER_SYMBOL strobes are emitted per symbol.
//  End of symbol (strobe with samp_cnt==SAMPLE_PER_SYMBOL-1):
//   - out_last=cur_last on that strobe.
//   - If FIFO non-empty: pop and load in the same cycle. Stay ACTIVE, phase continues, so the
//     strobe spacing stays exactly CLK_PER_SAMPLE across the symbol boundary (seamless).
//   - If FIFO empty: go to IDLE. If cur_last==0, set underrun=1 (sticky until reset).
//  Width rules: counters are $clog2 sized; the FIFO count is $clog2(FIFO_DEPTH)+1 bits.
//   Pointers wrap modulo FIFO_DEPTH.
//  in_last on a symbol does not stall the input: the next packet's symbols may queue.
//   They follow the last symbol back-to-back with no gap.
//  Async reset mid-packet: the sample in flight is dropped and the FIFO is flushed immediately.
//   No out_valid in the cycle after deassertion.
//  busy=0 only when IDLE and FIFO empty.
// CONFIGURATION
//  UPSAMPLE_ZERO_STUFF_EN defined:
//   - out_data = symbol on samp_cnt==0 strobes, 0 on all other strobes of that symbol.
//   - Strobe timing and out_last are unchanged.
//  Not defined: pure repetition, with out_data = symbol on every strobe.
// TESTING
//  1 Defaults. Push 1,0,1 (last on 3rd) back-to-back.
//    -> 24 strobes, 2 clk apart; data 8x1,8x0,8x1.
//    -> out_last only on 24th strobe; underrun=0; busy falls after it.
//  2 Push one symbol, in_last=0, then nothing.
//    -> 8 strobes then IDLE; underrun=1 and stays 1 after later full packets.
//  3 Hold in_valid=1 with out engine running.
//    -> in_ready drops after 4 entries + 1 in service.
//    -> No symbol lost or duplicated; seq 0..15 of DATA_WIDTH=4 appears in order, 8x each.
//  4 CLK_PER_SAMPLE=1, SAMPLE_PER_SYMBOL=4, continuous input.
//    -> out_valid stuck high; out_data changes every 4 cycles.
//  5 Assert rst_n=0 mid-symbol (strobe 3 of 8).
//    -> outputs 0 and in_ready=1 immediately; after release, a new packet starts at strobe 0.
//  6 With UPSAMPLE_ZERO_STUFF_EN, push 1,1 (last).
//    -> data 1,0,0,0,0,0,0,0,1,0,...; out_last on the 16th strobe.

Source files
------------

// File: rtl/symbol_repeat_upsample.sv
// symbol_repeat_upsample: FIFO-fed symbol repeater for BTLE TX; `UPSAMPLE_ZERO_STUFF_EN zero-stuffs non-first samples
module symbol_repeat_upsample #(
  parameter int SAMPLE_PER_SYMBOL = 8,
  parameter int CLK_PER_SAMPLE    = 2,
  parameter int DATA_WIDTH        = 1,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = CLK_PER_SAMPLE > 1 ? $clog2(CLK_PER_SAMPLE) : 1;
  localparam int SW = $clog2(SAMPLE_PER_SYMBOL);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0]   rd_word;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic [0:0]            state;
  logic [PW-1:0]         phase_cnt;
  logic [SW-1:0]         samp_cnt;
  logic [DATA_WIDTH-1:0] sym;
  logic                  cur_last;
  logic                  strobe, sym_end, not_empty, push, pop;

  assign not_empty = count != '0;
  assign in_ready  = count != (AW+1)'(FIFO_DEPTH);
  assign push      = in_valid & in_ready;
  assign strobe    = state == ACTIVE && phase_cnt == '0;
  assign sym_end   = strobe && samp_cnt == SW'(SAMPLE_PER_SYMBOL - 1);
  assign pop       = not_empty & (state == IDLE | sym_end);
  assign rd_word   = mem[rd_ptr];
  assign out_valid = strobe;
  assign out_last  = sym_end & cur_last;
  assign busy      = state == ACTIVE | not_empty;
`ifdef UPSAMPLE_ZERO_STUFF_EN
  assign out_data  = samp_cnt == '0 ? sym : '0;
`else
  assign out_data  = sym;
`endif

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  // FIFO pointers and occupancy; reset flushes immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Sample engine: load on pop, strobe every CLK_PER_SAMPLE, seamless across symbols
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      samp_cnt  <= '0;
      sym       <= '0;
      cur_last  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (pop) begin
        sym      <= rd_word[DATA_WIDTH-1:0];
        cur_last <= rd_word[DATA_WIDTH];
        state    <= ACTIVE;
      end else if (sym_end) begin
        state    <= IDLE;
        underrun <= underrun | ~cur_last;
      end
      if (state == ACTIVE)
        phase_cnt <= (sym_end && !not_empty) || phase_cnt == PW'(CLK_PER_SAMPLE - 1) ? '0 : phase_cnt + 1'b1;
      if (strobe) samp_cnt <= sym_end ? '0 : samp_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_symbol_repeat_upsample.sv
// tb_symbol_repeat_upsample: table-driven and scoreboard checks of the symbol repeater
module tb_symbol_repeat_upsample;
  localparam int SPS = 8;
  localparam int CPS = 2;
`ifdef UPSAMPLE_ZERO_STUFF_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  typedef struct {
    logic [3:0] data;
    logic       last;
    logic [3:0] exp_first;
    logic [3:0] exp_other;
    logic       exp_last;
  } vec_t;
  typedef struct {
    logic [3:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] in_data = '0, out_data;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready, out_valid, out_last, busy, underrun;
  logic [3:0] d4 = '0, o4_data;
  logic v4 = 1'b0, l4 = 1'b0, r4, o4_valid, o4_last, b4, u4_under;

  int tests = 0, fails = 0;
  exp_t q[$];
  bit drv_done;
  vec_t tbl[6];

  always #5 clk = ~clk;

  symbol_repeat_upsample #(.SAMPLE_PER_SYMBOL(SPS), .CLK_PER_SAMPLE(CPS), .DATA_WIDTH(4), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .underrun(underrun));

  symbol_repeat_upsample #(.SAMPLE_PER_SYMBOL(4), .CLK_PER_SAMPLE(1), .DATA_WIDTH(4), .FIFO_DEPTH(4)) u_fast (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_last(l4),
    .in_ready(r4), .out_data(o4_data), .out_valid(o4_valid), .out_last(o4_last),
    .busy(b4), .underrun(u4_under));

  function automatic vec_t mk(input logic [3:0] d, input logic l);
    return '{d, l, d, ZS ? 4'h0 : d, l};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input vec_t v, output int waits);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v.data;
    in_last  = v.last;
    waits = 0;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    for (int j = 0; j < SPS; j++)
      q.push_back('{j == 0 ? v.exp_first : v.exp_other, j == SPS - 1 ? v.exp_last : 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic monitor(input bit gap_chk);
    int cyc, prev;
    exp_t e;
    cyc = 0;
    prev = -1;
    while (cyc < 5000 && !(drv_done && q.size() == 0)) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (q.size() == 0) chk("extra_strobe", 1, 0);
        else begin
          e = q.pop_front();
          chk("data", out_data, e.data);
          chk("last", out_last, e.last);
          if (gap_chk && prev >= 0) chk("gap", cyc - prev, CPS);
          prev = cyc;
        end
      end else chk("last_without_valid", out_last, 0);
    end
    if (cyc >= 5000) chk("monitor_timeout", cyc, 0);
    @(negedge clk);
    chk("busy_after_drain", busy, 0);
  endtask

  initial begin
    int w, k, n;
    bit seen;
    tbl[0] = mk(4'h1, 1'b0);
    tbl[1] = mk(4'h0, 1'b0);
    tbl[2] = mk(4'h1, 1'b1);
    tbl[3] = mk(4'hA, 1'b0);
    tbl[4] = mk(4'h5, 1'b0);
    tbl[5] = mk(4'hF, 1'b1);

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // two packets back-to-back, expected seamless strobes
    drv_done = 0;
    fork
      begin
        foreach (tbl[i]) send(tbl[i], w);
        drv_done = 1;
      end
      monitor(1'b1);
    join
    chk("underrun_clean", underrun, 0);

    // starvation mid-packet
    drv_done = 0;
    fork
      begin send(mk(4'h3, 1'b0), w); drv_done = 1; end
      monitor(1'b0);
    join
    chk("underrun_set", underrun, 1);
    drv_done = 0;
    fork
      begin send(mk(4'h6, 1'b0), w); send(mk(4'h7, 1'b1), w); drv_done = 1; end
      monitor(1'b1);
    join
    chk("underrun_sticky", underrun, 1);

    // backpressure with a 16-symbol stream
    drv_done = 0;
    seen = 0;
    fork
      begin
        for (k = 0; k < 16; k++) begin
          send(mk(4'(k), k == 15), w);
          if (w > 0 && !seen) begin
            chk("first_stall_index", k, 5);
            seen = 1;
          end
        end
        chk("stall_seen", seen, 1);
        drv_done = 1;
      end
      monitor(1'b1);
    join

    // reset mid-symbol
    send(mk(4'h9, 1'b0), w);
    n = 0;
    k = 0;
    while (k < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) k++;
    end
    chk("reached_strobe3", k, 3);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_underrun", underrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_valid", out_valid, 0);
    drv_done = 0;
    fork
      begin send(mk(4'hC, 1'b1), w); drv_done = 1; end
      monitor(1'b1);
    join
    chk("post_rst_underrun", underrun, 0);

    // CLK_PER_SAMPLE=1 instance: strobe held high, data steps every 4 cycles
    fork
      begin
        for (int s = 1; s <= 4; s++) begin
          @(negedge clk);
          v4 = 1'b1;
          d4 = 4'(s);
          l4 = s == 4;
        end
        @(negedge clk);
        v4 = 1'b0;
        l4 = 1'b0;
      end
      begin
        n = 0;
        @(negedge clk);
        while (!o4_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("fast_start", o4_valid, 1);
        for (int i = 0; i < 16; i++) begin
          chk("fast_valid", o4_valid, 1);
          chk("fast_data", o4_data, (ZS && i % 4 != 0) ? 0 : i / 4 + 1);
          chk("fast_last", o4_last, i == 15);
          @(negedge clk);
        end
        chk("fast_stop", o4_valid, 0);
        chk("fast_underrun", u4_under, 0);
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
